// File: rtl/lsu_split.sv
// lsu_split: EX-stage load/store unit driving an OBI-style data bus through a registered FSM.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses into two beats; otherwise they raise err_o.
module lsu_split #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_addr_i,
  output logic              busy_o,
  output logic              rd_we_o,
  output logic [4:0]        rd_waddr_o,
  output logic [31:0]       rd_wdata_o,
  output logic              err_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic [31:0]       data_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
`ifdef LSU_MISALIGNED_SPLIT_EN
    S_REQ2,
    S_WAIT2,
`endif
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       rd_wdata_q, rd_wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        be_hi_q, be_hi_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [7:0]        be8;
`endif

  logic [3:0] be_base;
  logic       misal;
  logic       timeout;

  always_comb begin
    case (size_i)
      2'd0:    be_base = 4'b0001;
      2'd1:    be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
  end

  assign misal   = (size_i[1] && (addr_i[1:0] != 2'd0)) ||
                   ((size_i == 2'd1) && (addr_i[1:0] == 2'd3));
  assign timeout = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign be8 = {4'b0000, be_base} << addr_i[1:0];
`endif

  // Shift the addressed bytes down to lane 0, then extend; words ignore sext.
  function automatic logic [31:0] load_ext(input logic [63:0] pair, input logic [1:0] off,
                                           input logic [1:0] size, input logic sext);
    logic [31:0] sh;
    sh = 32'(pair >> {off, 3'b000});
    case (size)
      2'd0:    load_ext = {{24{sext & sh[7]}}, sh[7:0]};
      2'd1:    load_ext = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    off_d      = off_q;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d    = split_q;
    be_hi_d    = be_hi_q;
    wdata_hi_d = wdata_hi_q;
    lo_d       = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          we_d      = we_i;
          size_d    = size_i;
          sext_d    = sext_i;
          off_d     = addr_i[1:0];
          rd_addr_d = rd_addr_i;
          addr_d    = {addr_i[ADDR_W-1:2], 2'b00};
          wdata_d   = wdata_i << {addr_i[1:0], 3'b000};
          err_d     = 1'b0;
          state_d   = S_REQ;
`ifdef LSU_MISALIGNED_SPLIT_EN
          be_d       = be8[3:0];
          be_hi_d    = be8[7:4];
          wdata_hi_d = wdata_i >> (6'd32 - {1'b0, addr_i[1:0], 3'b000});
          split_d    = misal;
`else
          be_d = be_base << addr_i[1:0];
          if (misal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_REQ: begin
        if (data_gnt_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
          if (split_q) begin
            lo_d    = data_rdata_i;
            addr_d  = addr_q + ADDR_W'(4);
            be_d    = be_hi_q;
            wdata_d = wdata_hi_q;
            state_d = S_REQ2;
          end else
`endif
          begin
            state_d = S_RESP;
            if (!we_q) rd_wdata_d = load_ext({32'h0, data_rdata_i}, off_q, size_q, sext_q);
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      S_REQ2: begin
        if (data_gnt_i) begin
          state_d = S_WAIT2;
          cnt_d   = '0;
        end
      end
      S_WAIT2: begin
        if (data_rvalid_i) begin
          state_d = S_RESP;
          if (!we_q) rd_wdata_d = load_ext({data_rdata_i, lo_q}, off_q, size_q, sext_q);
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sext_q     <= 1'b0;
      off_q      <= '0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q    <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      off_q      <= off_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q    <= split_d;
      be_hi_q    <= be_hi_d;
      wdata_hi_q <= wdata_hi_d;
      lo_q       <= lo_d;
`endif
    end
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign data_req_o = (state_q == S_REQ) || (state_q == S_REQ2);
`else
  assign data_req_o = (state_q == S_REQ);
`endif
  assign busy_o       = ((state_q == S_IDLE) && req_i) ||
                        ((state_q != S_IDLE) && (state_q != S_RESP));
  assign data_we_o    = we_q && data_req_o;
  assign data_addr_o  = addr_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign rd_we_o      = (state_q == S_RESP) && !we_q && !err_q;
  assign err_o        = (state_q == S_RESP) && err_q;
  assign rd_waddr_o   = rd_addr_q;
  assign rd_wdata_o   = rd_wdata_q;

endmodule

// File: tb/tb_lsu_split.sv
// Self-checking bench for lsu_split: directed cases, watchdog, mid-transaction reset and random traffic
// against a byte-lane reference model; honours LSU_MISALIGNED_SPLIT_EN when defined.
module tb_lsu_split;
  localparam int ADDR_W = 32;
  localparam int TO     = 4;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0, we_i = 1'b0, sext_i = 1'b0;
  logic [1:0]  size_i = '0;
  logic [31:0] addr_i = '0, wdata_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        busy_o, rd_we_o, err_o, data_req_o, data_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_wdata_o, data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  lsu_split #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .busy_o(busy_o), .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .err_o(err_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [63:0] pair, input int o, input int sz,
                                             input bit sx);
    logic [63:0] v;
    int x;
    v = pair >> (8 * o);
    if (sz == 0) begin
      x = int'(v[7:0]);
      if (sx && x > 127) x -= 256;
    end else if (sz == 1) begin
      x = int'(v[15:0]);
      if (sx && x > 32767) x -= 65536;
    end else begin
      x = int'(v[31:0]);
    end
    return 32'(x);
  endfunction

  task automatic run_txn(input int id, input bit w, input int sz, input bit sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int gd, input int rvd,
                         input logic [31:0] r1, input logic [31:0] r2);
    int o, full, nb;
    bit mis;
    logic [31:0] ba[2];
    logic [31:0] bwd[2];
    logic [3:0] bbe[2];
    logic [63:0] wide, pair;
    logic [31:0] exp_rd;
    o    = int'(a[1:0]);
    mis  = (sz == 2 && o != 0) || (sz == 1 && o == 3);
    full = ((sz == 0) ? 1 : (sz == 1) ? 3 : 15) << o;
    bbe[0] = 4'(full % 16);
    bbe[1] = 4'(full / 16);
    wide   = {32'h0, wd} << (8 * o);
    bwd[0] = wide[31:0];
    bwd[1] = wide[63:32];
    ba[0]  = a & 32'hFFFF_FFFC;
    ba[1]  = ba[0] + 32'd4;
    pair   = mis ? {r2, r1} : {32'h0, r1};
    exp_rd = model_load(pair, o, sz, sx);

    @(negedge clk_i);
    req_i = 1'b1; we_i = w; size_i = 2'(sz); sext_i = sx; addr_i = a; wdata_i = wd; rd_addr_i = rd;
    #1;
    chk("busy_req_cycle", 32'(busy_o), 32'd1);
    chk("req_idle", 32'(data_req_o), 32'd0);
    if (mis && !SPLIT) begin
      @(negedge clk_i);
      chk("misal_err", 32'(err_o), 32'd1);
      chk("misal_rd_we", 32'(rd_we_o), 32'd0);
      chk("misal_no_bus", 32'(data_req_o), 32'd0);
      chk("misal_busy", 32'(busy_o), 32'd0);
      req_i = 1'b0;
      @(negedge clk_i);
      chk("misal_err_pulse", 32'(err_o), 32'd0);
      chk("misal_no_bus2", 32'(data_req_o), 32'd0);
      $display("TXN %0d we=%0d size=%0d addr=0x%08h misaligned -> error", id, w, sz, a);
      return;
    end
    nb = mis ? 2 : 1;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k <= gd; k++) begin
        @(negedge clk_i);
        data_rvalid_i = 1'b0;
        chk("bus_req", 32'(data_req_o), 32'd1);
        chk("bus_addr", data_addr_o, ba[b]);
        chk("bus_be", 32'(data_be_o), 32'(bbe[b]));
        chk("bus_we", 32'(data_we_o), 32'(w));
        chk("bus_wdata", data_wdata_o, bwd[b]);
        chk("busy_req", 32'(busy_o), 32'd1);
        data_gnt_i = (k == gd);
      end
      for (int k = 0; k <= rvd; k++) begin
        @(negedge clk_i);
        data_gnt_i = 1'b0;
        chk("wait_req_low", 32'(data_req_o), 32'd0);
        chk("wait_busy", 32'(busy_o), 32'd1);
        chk("wait_no_err", 32'(err_o), 32'd0);
        data_rvalid_i = (k == rvd);
        data_rdata_i  = (k == rvd) ? ((b == 0) ? r1 : r2) : $urandom();
      end
    end
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("resp_rd_we", 32'(rd_we_o), 32'(!w));
    chk("resp_err", 32'(err_o), 32'd0);
    chk("resp_busy", 32'(busy_o), 32'd0);
    if (!w) begin
      chk("resp_rd_wdata", rd_wdata_o, exp_rd);
      chk("resp_rd_waddr", 32'(rd_waddr_o), 32'(rd));
    end
    req_i = 1'b0;
    @(negedge clk_i);
    chk("idle_rd_we", 32'(rd_we_o), 32'd0);
    $display("TXN %0d we=%0d size=%0d sext=%0d addr=0x%08h wdata=0x%08h gw=%0d rw=%0d exp_rd=0x%08h",
             id, w, sz, sx, a, wd, gd, rvd, exp_rd);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    chk("rst_req", 32'(data_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_rd_we", 32'(rd_we_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_we", 32'(data_we_o), 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_wdata", data_wdata_o, 32'd0);
    chk("rst_waddr", 32'(rd_waddr_o), 32'd0);
    chk("rst_rd_wdata", rd_wdata_o, 32'd0);
    rst_ni = 1'b1;

    run_txn(1, 1'b0, 2, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 32'h8899AABB, 32'h0);
    run_txn(2, 1'b0, 0, 1'b1, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80123456, 32'h0);
    run_txn(3, 1'b0, 0, 1'b0, 32'h103, 32'h0, 5'd7, 1, 1, 32'h80123456, 32'h0);
    run_txn(4, 1'b1, 1, 1'b0, 32'h102, 32'h1234, 5'd0, 0, 0, 32'h0, 32'h0);
    run_txn(5, 1'b0, 2, 1'b0, 32'h101, 32'h0, 5'd9, 0, 0, 32'h44332211, 32'h88776655);
    run_txn(6, 1'b1, 2, 1'b0, 32'hFFFF_FFFD, 32'hA1B2C3D4, 5'd0, 1, 0, 32'h0, 32'h0);
    run_txn(7, 1'b0, 1, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd3, 0, 2, 32'hC3000000, 32'h12345681);

    // Watchdog: grant after 3 stalled cycles, then no response at all.
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sext_i = 1'b0; addr_i = 32'h200; rd_addr_i = 5'd4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("to_req_held", 32'(data_req_o), 32'd1);
      chk("to_addr_held", data_addr_o, 32'h200);
      data_gnt_i = (k == 3);
    end
    for (int k = 0; k < TO; k++) begin
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      chk("to_wait_busy", 32'(busy_o), 32'd1);
      chk("to_wait_no_err", 32'(err_o), 32'd0);
    end
    @(negedge clk_i);
    chk("to_err", 32'(err_o), 32'd1);
    chk("to_rd_we", 32'(rd_we_o), 32'd0);
    chk("to_busy", 32'(busy_o), 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    chk("to_err_pulse", 32'(err_o), 32'd0);
    $display("TXN watchdog addr=0x00000200 expect err after %0d wait cycles", TO);

    // Reset asserted while waiting for the response; a late rvalid must be ignored.
    @(negedge clk_i);
    req_i = 1'b1; addr_i = 32'h300;
    @(negedge clk_i);
    chk("mrst_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    chk("mrst_wait_busy", 32'(busy_o), 32'd1);
    rst_ni = 1'b0; req_i = 1'b0;
    @(negedge clk_i);
    chk("mrst_req_drop", 32'(data_req_o), 32'd0);
    chk("mrst_busy_drop", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    data_rvalid_i = 1'b0;
    chk("late_rv_rd_we", 32'(rd_we_o), 32'd0);
    chk("late_rv_busy", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk("late_rv_rd_we2", 32'(rd_we_o), 32'd0);
    chk("late_rv_data", rd_wdata_o, 32'd0);
    $display("TXN reset-in-wait addr=0x00000300 late rvalid ignored");

    for (int i = 0; i < 40; i++) begin
      run_txn(100 + i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), $urandom(), $urandom(), 5'($urandom_range(0, 31)),
              int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom(), $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
